id_stage: RTL and testbench

Instruction-decode stage of the pipelined MIPS core. It accepts fetched instruction words, holds the 32x32 register file and reads it, and selects the second operand. It rewrites I-type funct fields into the ALU's R-type function codes and registers `op1`/`op2`/`ins` plus control into the ID/EX pipeline register feeding the combinational ALU. It also takes the writeback port and inserts load-use bubbles.

---
 rtl/id_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_id_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: 32x32 register file, operand select, I-type funct
// rewrite, load-use bubble insertion. Optional macro WB_BYPASS_EN forwards writeback to reads.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ins,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] ins,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic        out_valid_q, out_valid_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] ins_q, ins_d;
  logic [4:0]  dest_q, dest_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;
  logic        rt_src;
  logic [31:0] rs_val, rt_val;

  logic [31:0] dec_op1, dec_op2, dec_ins;
  logic [4:0]  dec_dest;
  logic        dec_rw, dec_mr, dec_mw;

  logic        hazard, wb_stall, accept;

  assign opcode   = in_ins[31:26];
  assign rs       = in_ins[25:21];
  assign rt       = in_ins[20:16];
  assign rd       = in_ins[15:11];
  assign funct    = in_ins[5:0];
  assign imm      = in_ins[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign rt_src   = (opcode == OP_RTYPE) || (opcode == OP_SW);

  // Register reads; with bypass the in-flight writeback wins over the array.
  always_comb begin
    rs_val = (rs == 5'd0) ? 32'h0 : regs_q[rs];
    rt_val = (rt == 5'd0) ? 32'h0 : regs_q[rt];
`ifdef WB_BYPASS_EN
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rs)) rs_val = wb_data;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rt)) rt_val = wb_data;
`endif
  end

  always_comb begin
    dec_op1  = 32'h0;
    dec_op2  = 32'h0;
    dec_ins  = 32'h0;
    dec_dest = 5'd0;
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dec_op1 = rs_val;
        dec_op2 = rt_val;
        dec_ins = in_ins;
        if ((in_ins != 32'h0) && (funct != FN_JR)) begin
          dec_dest = rd;
          dec_rw   = 1'b1;
        end
      end
      OP_ADDI: begin
        dec_op1  = rs_val;
        dec_op2  = imm_sext;
        dec_ins  = {in_ins[31:6], FN_ADD};
        dec_dest = rt;
        dec_rw   = 1'b1;
      end
      OP_ADDIU: begin
        dec_op1  = rs_val;
        dec_op2  = imm_sext;
        dec_ins  = {in_ins[31:6], FN_ADDU};
        dec_dest = rt;
        dec_rw   = 1'b1;
      end
      OP_ANDI: begin
        dec_op1  = rs_val;
        dec_op2  = imm_zext;
        dec_ins  = {in_ins[31:6], FN_AND};
        dec_dest = rt;
        dec_rw   = 1'b1;
      end
      OP_ORI: begin
        dec_op1  = rs_val;
        dec_op2  = imm_zext;
        dec_ins  = {in_ins[31:6], FN_OR};
        dec_dest = rt;
        dec_rw   = 1'b1;
      end
      OP_LW: begin
        dec_op1  = rs_val;
        dec_op2  = imm_sext;
        dec_ins  = {in_ins[31:6], FN_ADDU};
        dec_dest = rt;
        dec_rw   = 1'b1;
        dec_mr   = 1'b1;
      end
      OP_SW: begin
        dec_op1 = rs_val;
        dec_op2 = imm_sext;
        dec_ins = {in_ins[31:6], FN_ADDU};
        dec_mw  = 1'b1;
      end
      default: ;
    endcase
  end

  // A load in ID/EX cannot feed the instruction right behind it; hold it one cycle.
  always_comb begin
    hazard = out_valid_q && mem_read_q && (dest_q != 5'd0) &&
             ((dest_q == rs) || (rt_src && (dest_q == rt)));
`ifdef WB_BYPASS_EN
    wb_stall = 1'b0;
`else
    wb_stall = wb_we && (wb_addr != 5'd0) &&
               ((wb_addr == rs) || (rt_src && (wb_addr == rt)));
`endif
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !wb_stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    ins_d       = ins_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = dec_op1;
      op2_d       = dec_op2;
      ins_d       = dec_ins;
      dest_d      = dec_dest;
      reg_write_d = dec_rw;
      mem_read_d  = dec_mr;
      mem_write_d = dec_mw;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      op1_d       = 32'h0;
      op2_d       = 32'h0;
      ins_d       = 32'h0;
      dest_d      = 5'd0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_addr != 5'd0)) regs_d[wb_addr] = wb_data;
    regs_d[0] = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op1_q       <= 32'h0;
      op2_q       <= 32'h0;
      ins_q       <= 32'h0;
      dest_q      <= 5'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      out_valid_q <= out_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      ins_q       <= ins_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign ins       = ins_q;
  assign dest      = dest_q;
  assign reg_write = reg_write_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: reference decode from the ISA table, randomized traffic,
// directed load-use, backpressure, writeback and reset scenarios.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_ins = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] op1, op2, ins;
  logic [4:0]  dest;
  logic        reg_write, mem_read, mem_write;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] ins;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_valid;
  exp_t        m_held;
  int          vectors = 0;
  int          miscompares = 0;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .ins(ins), .dest(dest),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference read: $0 is zero; bypass (if built in) sees the writeback in flight.
  function automatic logic [31:0] ref_read(logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (wb_we && wb_addr == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic exp_t ref_decode(logic [31:0] w);
    exp_t e;
    logic [31:0] a, sx, zx;
    a  = ref_read(w[25:21]);
    sx = 32'(signed'(w[15:0]));
    zx = {16'h0, w[15:0]};
    e  = '0;
    case (w[31:26])
      6'o00: begin
        e.op1 = a; e.op2 = ref_read(w[20:16]); e.ins = w;
        if (w != 0 && w[5:0] != 6'o10) begin e.dest = w[15:11]; e.rw = 1; end
      end
      6'o10: begin e.op1 = a; e.op2 = sx; e.ins = {w[31:6], 6'o40}; e.dest = w[20:16]; e.rw = 1; end
      6'o11: begin e.op1 = a; e.op2 = sx; e.ins = {w[31:6], 6'o41}; e.dest = w[20:16]; e.rw = 1; end
      6'o14: begin e.op1 = a; e.op2 = zx; e.ins = {w[31:6], 6'o44}; e.dest = w[20:16]; e.rw = 1; end
      6'o15: begin e.op1 = a; e.op2 = zx; e.ins = {w[31:6], 6'o45}; e.dest = w[20:16]; e.rw = 1; end
      6'o43: begin e.op1 = a; e.op2 = sx; e.ins = {w[31:6], 6'o41}; e.dest = w[20:16]; e.rw = 1; e.mr = 1; end
      6'o53: begin e.op1 = a; e.op2 = sx; e.ins = {w[31:6], 6'o41}; e.mw = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic ref_ready(logic [31:0] w, logic ordy);
    logic [4:0] rs, rt;
    logic src_rt, haz, wbs;
    rs = w[25:21];
    rt = w[20:16];
    src_rt = (w[31:26] == 6'o00) || (w[31:26] == 6'o53);
    haz = m_valid && m_held.mr && m_held.dest != 0 &&
          (m_held.dest == rs || (src_rt && m_held.dest == rt));
`ifdef WB_BYPASS_EN
    wbs = 1'b0;
`else
    wbs = wb_we && wb_addr != 0 && (wb_addr == rs || (src_rt && wb_addr == rt));
`endif
    return (!m_valid || ordy) && !haz && !wbs;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {31'h0, out_valid} | op1 | op2 | ins | {27'h0, dest} |
                {29'h0, reg_write, mem_read, mem_write}, 32'h0);
  endtask

  // Monitor: every consumed ID/EX entry is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard: unexpected output ins=%h with empty queue", ins);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({op1, op2, ins, dest, reg_write, mem_read, mem_write} !== e) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: got op1=%h op2=%h ins=%h dest=%0d rw=%b mr=%b mw=%b, expected op1=%h op2=%h ins=%h dest=%0d rw=%b mr=%b mw=%b",
                   op1, op2, ins, dest, reg_write, mem_read, mem_write,
                   e.op1, e.op2, e.ins, e.dest, e.rw, e.mr, e.mw);
        end
      end
    end
  end

  // One cycle of traffic; the model decides acceptance and advances with the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic ordy,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               output logic acc);
    logic rdy;
    @(posedge clk);
    #1;
    checkOutput("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
    in_valid = v; in_ins = w; out_ready = ordy;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    rdy = ref_ready(w, ordy);
    checkOutput("in_ready", {31'h0, in_ready}, {31'h0, rdy});
    acc = v && rdy;
    if (acc) begin
      m_held  = ref_decode(w);
      m_valid = 1'b1;
      exp_q.push_back(m_held);
    end else if (ordy) begin
      m_valid = 1'b0;
      m_held  = '0;
    end
    if (we && wa != 0) m_regs[wa] = wd;
  endtask

  task automatic sendIns(input logic [31:0] w, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
    logic acc;
    int n;
    n = 0;
    applyStimulus(1'b1, w, 1'b1, we, wa, wd, acc);
    while (!acc && n < 10) begin
      applyStimulus(1'b1, w, 1'b1, 1'b0, 5'd0, 32'h0, acc);
      n++;
    end
    if (!acc) begin
      vectors++; miscompares++;
      $display("[TB] FAIL accept_timeout: ins %h not accepted, expected within 10 cycles", w);
    end
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b1; in_ins = 32'h00A51820; out_ready = 1'b1; wb_we = 1'b0;
    #1;
    checkAllZero("reset_async");
    repeat (2) begin
      @(negedge clk);
      checkAllZero("reset_held");
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0;
    m_held  = '0;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] genIns();
    logic [4:0] rs, rt, rd;
    logic [15:0] im;
    logic [5:0] fn [7];
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    fn = '{6'o40, 6'o41, 6'o42, 6'o44, 6'o45, 6'o52, 6'o10};
    case ($urandom_range(0, 10))
      0, 1, 2: return {6'o00, rs, rt, rd, 5'($urandom_range(0, 3)), fn[$urandom_range(0, 6)]};
      3:  return {6'o10, rs, rt, im};
      4:  return {6'o11, rs, rt, im};
      5:  return {6'o14, rs, rt, im};
      6:  return {6'o15, rs, rt, im};
      7, 8: return {6'o43, rs, rt, im};
      9:  return {6'o53, rs, rt, im};
      default: return ($urandom_range(0, 1) == 0) ? 32'h0 : {6'o04, rs, rt, im};
    endcase
  endfunction

  initial begin
    logic acc;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0;
    m_held  = '0;
    doReset();

    sendIns(32'h00A01820, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 32'h7, acc);
    sendIns(32'h00A51820, 1'b0, 5'd0, 32'h0);
    sendIns(32'h2002FFFF, 1'b0, 5'd0, 32'h0);
    sendIns(32'h3402FFFF, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd4, 32'hCAFE0000, acc);
    sendIns(32'h8C240000, 1'b0, 5'd0, 32'h0);
    sendIns(32'h00843020, 1'b0, 5'd0, 32'h0);
    sendIns(32'h8C240000, 1'b0, 5'd0, 32'h0);
    sendIns(32'h00E73020, 1'b0, 5'd0, 32'h0);
    sendIns(32'hAC240010, 1'b0, 5'd0, 32'h0);
    sendIns(32'h03E00008, 1'b0, 5'd0, 32'h0);
    sendIns(32'h00000000, 1'b0, 5'd0, 32'h0);
    sendIns(32'h08000010, 1'b0, 5'd0, 32'h0);
    sendIns(32'h3085FFFF, 1'b0, 5'd0, 32'h0);
    sendIns(32'h2486FFF0, 1'b0, 5'd0, 32'h0);

    repeat (3) applyStimulus(1'b1, 32'h00A53820, 1'b0, 1'b1, 5'd5, 32'h55, acc);
    applyStimulus(1'b1, 32'h00A53820, 1'b1, 1'b0, 5'd0, 32'h0, acc);

    sendIns(32'h01205020, 1'b1, 5'd9, 32'h00001234);

    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, genIns(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom, acc);
    end

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, acc);
    repeat (2) applyStimulus(1'b1, 32'h8CA60000, 1'b0, 1'b0, 5'd0, 32'h0, acc);
    doReset();
    sendIns(32'h00A63820, 1'b0, 5'd0, 32'h0);

    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, acc);
    checkOutput("queue_drained", exp_q.size(), 32'h0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
